exp_diff_pipe: RTL and testbench

EXP_DIFF_PIPE -- requirements
Module: exp_diff_pipe

---
 rtl/fp32_pkg.sv | 16 +
 rtl/exp_diff_skid.sv | 56 +++++
 rtl/exp_diff_pipe.sv | 77 +++++++
 tb/tb_exp_diff_pipe.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared widths and result record for the exponent-difference stage.
package fp32_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 24;

  // Field order matches the per-instance record built in exp_diff_pipe.
  typedef struct packed {
    logic [EXP_W_DEF-1:0] diff;
    logic [EXP_W_DEF-1:0] exp_max;
    logic                 swap;
    logic                 zero;
    logic                 sat;
  } exp_res_t;

endpackage

// File: rtl/exp_diff_skid.sv
// Two-entry in-order result buffer, generic over the record width W.
// Slot 0 is always the head, so the output is a plain register read.
module exp_diff_skid #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [1:0][W-1:0] mem;
  logic [1:0]        count;
  logic              rdy_en;
  logic              push, pop;

  // rdy_en keeps in_ready low until the first edge after reset release.
  assign push_ready = rdy_en && (count < 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = pop_valid ? mem[0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count  <= 2'd0;
      rdy_en <= 1'b0;
      mem    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            mem[count[0]] <= push_data;
            count         <= count + 2'd1;
          end
          2'b01: begin
            mem[0] <= mem[1];
            count  <= count - 2'd1;
          end
          // Only reachable with count==1: head leaves, new entry becomes head.
          2'b11: mem[0] <= push_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/exp_diff_pipe.sv
// Exponent compare/subtract feeding a 2-entry result buffer (1-cycle latency).
// Optional clamp of the shift amount to MANT_W+2 under `EXP_DIFF_SAT_EN.
module exp_diff_pipe
  import fp32_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_diff,
  output logic [EXP_W-1:0] out_exp_max,
  output logic             out_swap,
  output logic             out_zero,
  output logic             out_sat
);

  typedef struct packed {
    logic [EXP_W-1:0] diff;
    logic [EXP_W-1:0] exp_max;
    logic             swap;
    logic             zero;
    logic             sat;
  } res_t;

  res_t             res_in, res_out;
  logic [EXP_W-1:0] exp_min, diff_raw;
  logic             swap;

  assign swap     = (exp_b > exp_a);
  assign exp_min  = swap ? exp_a : exp_b;
  assign diff_raw = (swap ? exp_b : exp_a) - exp_min;

  always_comb begin
    res_in         = '0;
    res_in.exp_max = swap ? exp_b : exp_a;
    res_in.swap    = swap;
    res_in.zero    = (exp_a == exp_b);
`ifdef EXP_DIFF_SAT_EN
    // Shifting past the guard/sticky positions gives the same result.
    if (32'(diff_raw) > 32'(MANT_W + 2)) begin
      res_in.diff = EXP_W'(MANT_W + 2);
      res_in.sat  = 1'b1;
    end else begin
      res_in.diff = diff_raw;
    end
`else
    res_in.diff = diff_raw;
`endif
  end

  exp_diff_skid #(.W($bits(res_t))) u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (res_in),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (res_out)
  );

  assign out_diff    = res_out.diff;
  assign out_exp_max = res_out.exp_max;
  assign out_swap    = res_out.swap;
  assign out_zero    = res_out.zero;
  assign out_sat     = res_out.sat;

endmodule

// File: tb/tb_exp_diff_pipe.sv
// Random + directed bench for exp_diff_pipe against a queue-based model.
module tb_exp_diff_pipe;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 24;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid, out_swap, out_zero, out_sat;
  logic [EXP_W-1:0] exp_a, exp_b, out_diff, out_exp_max;

  exp_diff_pipe #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .exp_b(exp_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_exp_max(out_exp_max),
    .out_swap(out_swap), .out_zero(out_zero), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int diff;
    int mx;
    bit swap;
    bit zero;
    bit sat;
  } mrec_t;

  mrec_t q[$];
  bit    rdy_m;
  int    errs = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic mrec_t ref_rec(input int a, input int b);
    mrec_t r;
    r.diff = (a >= b) ? a - b : b - a;
    r.mx   = (a >= b) ? a : b;
    r.swap = (b > a);
    r.zero = (a == b);
    r.sat  = 1'b0;
`ifdef EXP_DIFF_SAT_EN
    if (r.diff > MANT_W + 2) begin
      r.diff = MANT_W + 2;
      r.sat  = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic check_outs();
    mrec_t h;
    h = '{0, 0, 1'b0, 1'b0, 1'b0};
    if (q.size() > 0) h = q[0];
    chk("in_ready",  32'(in_ready),    32'(rdy_m && q.size() < 2));
    chk("out_valid", 32'(out_valid),   32'(q.size() > 0));
    chk("diff",      32'(out_diff),    32'(h.diff));
    chk("exp_max",   32'(out_exp_max), 32'(h.mx));
    chk("swap",      32'(out_swap),    32'(h.swap));
    chk("zero",      32'(out_zero),    32'(h.zero));
    chk("sat",       32'(out_sat),     32'(h.sat));
  endtask

  // One clock: drive at negedge, update model at the edge, check at next negedge.
  task automatic step(input bit rst, input bit fl, input bit iv, input int a,
                      input int b, input bit ordy);
    bit push, pop;
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    exp_a = EXP_W'(a); exp_b = EXP_W'(b);
    push = iv && rdy_m && (q.size() < 2);
    pop  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      rdy_m = 1'b0;
    end else if (fl) begin
      q.delete();
      rdy_m = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_rec(a, b));
      rdy_m = 1'b1;
    end
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    int a, b;
    rdy_m = 1'b0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_a = '0; exp_b = '0;
    @(negedge clk);
    step(0, 0, 1, 8'h12, 8'h34, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);                 // in_ready rises here

    // Scenario 1
    step(1, 0, 1, 8'h85, 8'h80, 1);
    chk("s1_diff", 32'(out_diff), 32'd5);
    chk("s1_max",  32'(out_exp_max), 32'h85);
    // Scenario 2
    step(1, 0, 1, 8'h10, 8'h7F, 1);
    chk("s2_swap", 32'(out_swap), 32'd1);
`ifdef EXP_DIFF_SAT_EN
    chk("s2_diff", 32'(out_diff), 32'd26);
`else
    chk("s2_diff", 32'(out_diff), 32'h6F);
`endif
    // Scenario 6
    step(1, 0, 1, 8'hFF, 8'hFF, 1);
    chk("s6_zero", 32'(out_zero), 32'd1);
    step(1, 0, 0, 0, 0, 1);

    // Scenario 3: stall, three pairs, then drain
    step(1, 0, 1, 8'h01, 8'h02, 0);
    step(1, 0, 1, 8'h30, 8'h03, 0);
    chk("s3_full", 32'(in_ready), 32'd0);
    step(1, 0, 1, 8'h40, 8'h44, 0);
    step(1, 0, 1, 8'h40, 8'h44, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);

    // Scenario 4: full, flush with in_valid
    step(1, 0, 1, 8'h05, 8'h06, 0);
    step(1, 0, 1, 8'h07, 8'h08, 0);
    step(1, 1, 1, 8'h09, 8'h0A, 1);
    chk("s4_valid", 32'(out_valid), 32'd0);

    // Scenario 5: reset mid-stream with two buffered
    step(1, 0, 1, 8'h05, 8'h06, 0);
    step(1, 0, 1, 8'h07, 8'h08, 0);
    step(0, 0, 1, 8'h09, 8'h0A, 1);
    chk("s5_rdy", 32'(in_ready), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("s5_rdy_rel", 32'(in_ready), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? a : int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = 255;
      step($urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0, a, b, $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
